// File: rtl/time_tmr_triplet_end.sv
// Receive end of a time-redundant TMR stream: gathers three same-ID copies,
// majority-votes them, holds the upstream arbiter mid-triplet and flags faults.
module time_tmr_triplet_end #(
    parameter int unsigned DataWidth   = 8,
    parameter int unsigned IDSize      = 5,
    parameter int unsigned LockTimeout = 60
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic [IDSize-1:0]    id_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 lock_o,
    output logic                 fault_detected_o
);

    localparam int unsigned CntWidth = $clog2(LockTimeout + 1);

    // State code equals the number of stored copies for the partial states.
    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StPart1 = 2'd1;
    localparam logic [1:0] StPart2 = 2'd2;
    localparam logic [1:0] StOut   = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [DataWidth-1:0] slot0_data_q, slot1_data_q, result_q;
    logic [IDSize-1:0]    slot0_id_q;
    logic [CntWidth-1:0]  tmo_cnt_q;
    logic                 fault_q;

    logic                 in_part, ready_int, accept, id_match;
    logic                 id_abort, completes, vote_mismatch, timeout;
    logic                 handshake, load_slot0, load_slot1;
    logic [DataWidth-1:0] vote;

    // Handshake: a transfer happens on a cycle where valid and ready are both
    // high; valid never waits on ready, and ready never looks at valid.
    always_comb begin
        in_part       = (state_q == StPart1) || (state_q == StPart2);
        ready_int     = (state_q == StOut) ? ready_i : 1'b1;
        accept        = valid_i && ready_int;
        id_match      = (id_i == slot0_id_q);
        id_abort      = in_part && accept && !id_match;
        completes     = (state_q == StPart2) && accept && id_match;
        vote          = (slot0_data_q & slot1_data_q) | (slot0_data_q & data_i)
                      | (slot1_data_q & data_i);
        vote_mismatch = completes && ((slot0_data_q != slot1_data_q)
                                   || (slot1_data_q != data_i));
        // The increment that would reach LockTimeout is the timeout cycle.
        timeout       = in_part && !accept
                      && (tmo_cnt_q == CntWidth'(LockTimeout - 1));
        handshake     = (state_q == StOut) && ready_i;
        load_slot0    = accept && ((state_q == StEmpty) || (state_q == StOut) || id_abort);
        load_slot1    = accept && (state_q == StPart1) && id_match;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: if (accept) state_d = StPart1;
            StPart1: begin
                if (accept)       state_d = id_match ? StPart2 : StPart1;
                else if (timeout) state_d = StEmpty;
            end
            StPart2: begin
                if (accept)       state_d = id_match ? StOut : StPart1;
                else if (timeout) state_d = StEmpty;
            end
            StOut:   if (handshake) state_d = accept ? StPart1 : StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StEmpty;
            slot0_data_q <= '0;
            slot1_data_q <= '0;
            slot0_id_q   <= '0;
            result_q     <= '0;
            tmo_cnt_q    <= '0;
            fault_q      <= 1'b0;
        end else if (!enable_i) begin
            state_q      <= StEmpty;
            slot0_data_q <= '0;
            slot1_data_q <= '0;
            slot0_id_q   <= '0;
            result_q     <= '0;
            tmo_cnt_q    <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_slot0) begin
                slot0_data_q <= data_i;
                slot0_id_q   <= id_i;
            end
            if (load_slot1) slot1_data_q <= data_i;
            if (completes)  result_q     <= vote;
            if (accept || !in_part || timeout) tmo_cnt_q <= '0;
            else                               tmo_cnt_q <= tmo_cnt_q + CntWidth'(1);
            fault_q <= id_abort || vote_mismatch || timeout;
        end
    end

    assign ready_o          = enable_i ? ready_int : ready_i;
    assign valid_o          = enable_i ? (state_q == StOut) : valid_i;
    assign data_o           = enable_i ? result_q : data_i;
    assign lock_o           = enable_i && in_part;
    assign fault_detected_o = enable_i && fault_q;

endmodule
